ysyx_22040386_ifu_fetch: RTL and testbench
==========================================

// Module: ysyx_22040386_ifu_fetch
// PURPOSE
//  Instruction fetch unit: owns the PC and fetches 32-bit instructions from instruction
//  memory over a valid/ready request and response interface. Presents each instruction
//  and its PC to the decode stage with a valid/ready handshake. Accepts PC redirects from
//  jal/jalr/branch resolution, and discards a fetch that is in flight when a redirect hits.
// PARAMETERS
//  RESET_PC  64'h8000_0000  PC value loaded on reset
//  XLEN      64             PC and address width
// PORTS
//  clk             in   1     clock, rising edge
//  rst             in   1     asynchronous reset, active-high
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts the request this cycle
//  imem_addr       out  XLEN  fetch address; equals pc
//  imem_rsp_valid  in   1     response data valid; one response per accepted request
//  imem_rsp_data   in   32    fetched instruction word
//  inst_valid      out  1     instruction valid to decode
//  inst_ready      in   1     decode consumes the instruction
//  inst            out  32    instruction to decode
//  inst_pc         out  XLEN  PC of inst
//  redirect_valid  in   1     redirect the PC (jump or branch taken)
//  redirect_pc     in   XLEN  redirect target; bits [1:0] are forced to 0
// BEHAVIOUR
//  Reset is async and active-high. On reset: pc=RESET_PC, state=REQ, kill=0, inst=0,
//   inst_pc=0, and every output is 0 except imem_addr=RESET_PC.
//   When rst is released, imem_req_valid=1 in the first cycle.
//  State REQ: imem_req_valid=1, imem_addr=pc.
//   On imem_req_ready, go to WAIT.
//  State WAIT: imem_req_valid=0.
//   On imem_rsp_valid with kill=0: latch inst=rsp_data and inst_pc=pc, then go to OUT.
//   On imem_rsp_valid with kill=1: drop the data, clear kill, then go to REQ.
//  State OUT: inst_valid=1 and inst/inst_pc are held stable.
//   On inst_ready: pc<=pc+4 (XLEN wrap-around), then go to REQ.
//  Latency: an accepted request with a 1-cycle response gives inst_valid 2 cycles after
//   the request handshake. Steady state is one instruction per 3 cycles; no prefetch.
//  Redirect (1 cycle pulse; always has priority over pc+4):
//   REQ: pc<=redirect_pc. If imem_req_ready fires in the same cycle, that request is for
//    the old pc: go to WAIT with kill=1. Otherwise stay in REQ with the new address next
//    cycle.
//   WAIT: pc<=redirect_pc, kill<=1. If imem_rsp_valid fires in the same cycle, drop the
//    response and go straight to REQ with kill=0.
//   OUT: pc<=redirect_pc, go to REQ, inst_valid deasserts next cycle. If inst_ready is high
//    in the same cycle, the instruction counts as consumed; otherwise it is discarded.
//  imem_rsp_valid outside WAIT is ignored; an assertion flags it.
//  No stall input is needed: decode backpressure is inst_ready low in OUT.
//  PC arithmetic is unsigned XLEN with wrap-around: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.
//  rst asserted mid-fetch returns to the reset state immediately. A response that arrives
//   after reset is released counts as "outside WAIT" or is dropped by the REQ/WAIT
//   protocol. The memory model must flush on rst.
// TESTING
//  1 Reset, memory always ready, 1-cycle response of 32'h00000013
//    -> inst_pc=8000_0000 then 8000_0004, each inst_valid 2 cycles after its request.
//  2 inst_ready held low for 5 cycles in OUT
//    -> inst and inst_pc stable, imem_req_valid=0, pc not incremented until ready.
//  3 redirect_valid with 8000_0100 while in WAIT, response arrives 3 cycles later
//    -> response dropped, next imem_addr=8000_0100, no inst_valid for the stale word.
//  4 redirect to 8000_0203 in OUT with inst_ready=1
//    -> instruction consumed once, next imem_addr=8000_0200.
//  5 imem_req_ready low for 4 cycles
//    -> imem_req_valid and imem_addr stable; a redirect in cycle 2 changes the addr to
//       the target.
//  6 rst pulsed while in WAIT
//    -> all outputs 0 at once; after release, request at RESET_PC; the old response
//       is never delivered.

Source files
------------

// File: rtl/ysyx_22040386_ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to instruction memory
// and hands each instruction to decode; redirects kill any fetch still in flight.
module ysyx_22040386_ifu_fetch #(
  parameter int                XLEN     = 64,
  parameter logic [XLEN-1:0]   RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [XLEN-1:0]   pc_r, pc_s;
  logic              kill_r, kill_s;
  logic [31:0]       inst_r, inst_s;
  logic [XLEN-1:0]   inst_pc_r, inst_pc_s;
  logic [XLEN-1:0]   redir_pc_s;
  logic [XLEN-1:0]   pc_inc_s;

  assign redir_pc_s = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_inc_s   = pc_r + {{(XLEN-3){1'b0}}, 3'b100};

  // State, PC, kill flag and the decode-side instruction latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_REQ;
      pc_r      <= RESET_PC;
      kill_r    <= 1'b0;
      inst_r    <= 32'h0000_0000;
      inst_pc_r <= {XLEN{1'b0}};
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      kill_r    <= kill_s;
      inst_r    <= inst_s;
      inst_pc_r <= inst_pc_s;
    end
  end

  // Next-state logic; a redirect always wins over the sequential pc+4
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    kill_s    = kill_r;
    inst_s    = inst_r;
    inst_pc_s = inst_pc_r;
    case (state_r)
      ST_REQ: begin
        if (redirect_valid) begin
          pc_s = redir_pc_s;
          // A request accepted this cycle carries the old pc, so its reply is junk
          if (imem_req_ready) begin
            state_s = ST_WAIT;
            kill_s  = 1'b1;
          end else begin
            state_s = ST_REQ;
          end
        end else if (imem_req_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_s = redir_pc_s;
          if (imem_rsp_valid) begin
            kill_s  = 1'b0;
            state_s = ST_REQ;
          end else begin
            kill_s  = 1'b1;
            state_s = ST_WAIT;
          end
        end else if (imem_rsp_valid) begin
          if (kill_r) begin
            kill_s  = 1'b0;
            state_s = ST_REQ;
          end else begin
            inst_s    = imem_rsp_data;
            inst_pc_s = pc_r;
            state_s   = ST_OUT;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (redirect_valid) begin
          pc_s    = redir_pc_s;
          state_s = ST_REQ;
        end else if (inst_ready) begin
          pc_s    = pc_inc_s;
          state_s = ST_REQ;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_REQ;
        kill_s  = 1'b0;
      end
    endcase
  end

  // Request is masked while reset is held so every output reads zero in reset
  assign imem_req_valid = (state_r == ST_REQ) && !rst;
  assign imem_addr      = pc_r;
  assign inst_valid     = (state_r == ST_OUT);
  assign inst           = inst_r;
  assign inst_pc        = inst_pc_r;

  ysyx_22040386_ifu_fetch_chk u_chk (
    .clk            (clk),
    .rst            (rst),
    .imem_rsp_valid (imem_rsp_valid),
    .in_wait        (state_r == ST_WAIT)
  );

endmodule

// Protocol checker: memory responses are only legal while a fetch is outstanding.
module ysyx_22040386_ifu_fetch_chk (
  input logic clk,
  input logic rst,
  input logic imem_rsp_valid,
  input logic in_wait
);

  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && !in_wait));

endmodule

// File: tb/tb_ysyx_22040386_ifu_fetch.sv
// Directed bench for the fetch unit: hand-computed PCs, instructions and handshake counts.
module tb_ysyx_22040386_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int n_cmp;
  int n_bad;
  int hs_cnt;
  int hs_exp;

  ysyx_22040386_ifu_fetch #(
    .XLEN     (64),
    .RESET_PC (64'h0000_0000_8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count decode handshakes as the DUT sees them
  always @(posedge clk) begin
    if (!rst && inst_valid && inst_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch from a REQ state at exp_pc with an immediate grant and 1-cycle response; ends in OUT
  task automatic do_fetch(input string tag, input logic [31:0] data, input logic [63:0] exp_pc);
    chk({tag, "_req_valid"}, {63'd0, imem_req_valid}, 64'd1);
    chk({tag, "_addr"}, imem_addr, exp_pc);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk({tag, "_wait_req"}, {63'd0, imem_req_valid}, 64'd0);
    chk({tag, "_wait_iv"}, {63'd0, inst_valid}, 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0000_0000;
    chk({tag, "_iv"}, {63'd0, inst_valid}, 64'd1);
    chk({tag, "_inst"}, {32'd0, inst}, {32'd0, data});
    chk({tag, "_inst_pc"}, inst_pc, exp_pc);
  endtask

  task automatic consume(input string tag, input logic [63:0] next_pc);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    hs_exp++;
    chk({tag, "_iv_drop"}, {63'd0, inst_valid}, 64'd0);
    chk({tag, "_next_req"}, {63'd0, imem_req_valid}, 64'd1);
    chk({tag, "_next_addr"}, imem_addr, next_pc);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    hs_cnt = 0;
    hs_exp = 0;
    rst = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0000_0000;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    tick();
    tick();

    // Reset values
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst_addr", imem_addr, 64'h0000_0000_8000_0000);
    chk("rst_iv", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_req_valid", {63'd0, imem_req_valid}, 64'd1);

    // 1: two sequential fetches of a nop
    do_fetch("t1a", 32'h0000_0013, 64'h0000_0000_8000_0000);
    consume("t1a", 64'h0000_0000_8000_0004);
    do_fetch("t1b", 32'h0000_0013, 64'h0000_0000_8000_0004);

    // 2: decode backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_iv", {63'd0, inst_valid}, 64'd1);
      chk("t2_inst", {32'd0, inst}, 64'h13);
      chk("t2_inst_pc", inst_pc, 64'h0000_0000_8000_0004);
      chk("t2_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("t2_pc_held", imem_addr, 64'h0000_0000_8000_0004);
    end
    consume("t2", 64'h0000_0000_8000_0008);

    // 3: redirect while waiting, stale response three cycles later
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_addr_new", imem_addr, 64'h0000_0000_8000_0100);
    chk("t3_no_req", {63'd0, imem_req_valid}, 64'd0);
    tick();
    tick();
    chk("t3_wait_iv", {63'd0, inst_valid}, 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("t3_stale_iv", {63'd0, inst_valid}, 64'd0);
    chk("t3_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("t3_req_addr", imem_addr, 64'h0000_0000_8000_0100);

    // 4: redirect in OUT together with inst_ready, target low bits cleared
    do_fetch("t4", 32'h0010_0093, 64'h0000_0000_8000_0100);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0203;
    consume("t4", 64'h0000_0000_8000_0200);
    redirect_valid = 1'b0;

    // 5: memory not ready for 4 cycles, redirect in cycle 2
    chk("t5_c1_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("t5_c1_addr", imem_addr, 64'h0000_0000_8000_0200);
    tick();
    chk("t5_c2_addr", imem_addr, 64'h0000_0000_8000_0200);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0400;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t5_c34_valid", {63'd0, imem_req_valid}, 64'd1);
      chk("t5_c34_addr", imem_addr, 64'h0000_0000_8000_0400);
      tick();
    end
    do_fetch("t5", 32'h0000_0073, 64'h0000_0000_8000_0400);
    consume("t5", 64'h0000_0000_8000_0404);

    // Redirect in REQ while the old request is granted: its reply must be dropped
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_1000;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("kr_no_req", {63'd0, imem_req_valid}, 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    tick();
    imem_rsp_valid = 1'b0;
    chk("kr_iv", {63'd0, inst_valid}, 64'd0);
    chk("kr_addr", imem_addr, 64'h0000_0000_8000_1000);

    // Redirect in OUT without inst_ready: instruction discarded
    do_fetch("disc", 32'h2222_2222, 64'h0000_0000_8000_1000);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_2000;
    tick();
    redirect_valid = 1'b0;
    chk("disc_iv", {63'd0, inst_valid}, 64'd0);
    chk("disc_addr", imem_addr, 64'h0000_0000_8000_2000);

    // 6: reset pulse while a fetch is outstanding
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("t6_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("t6_addr", imem_addr, 64'h0000_0000_8000_0000);
    chk("t6_iv", {63'd0, inst_valid}, 64'd0);
    chk("t6_inst", {32'd0, inst}, 64'd0);
    chk("t6_inst_pc", inst_pc, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    do_fetch("t6", 32'h0000_0013, 64'h0000_0000_8000_0000);
    consume("t6", 64'h0000_0000_8000_0004);

    // PC wrap-around at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    do_fetch("wrap", 32'h0000_0013, 64'hFFFF_FFFF_FFFF_FFFC);
    consume("wrap", 64'h0000_0000_0000_0000);

    tick();
    chk("hs_count", 64'(hs_cnt), 64'(hs_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
